spi_reg_controller: RTL and testbench
=====================================

Name: spi_reg_controller

Overview:
SPI controller (initiator) for the 16-bit register-write/read frame that our SPI peripheral accepts. It takes one register command at a time over a valid/ready handshake and serialises it onto SCLK/nCS/COPI in SPI mode 0. It samples CIPO into a read-data byte and reports completion with a one-cycle response pulse. It sits in bring-up and loopback configurations, where it drives the peripheral's ui_in SPI pins from on-chip logic.

Parameters:
HALF_PERIOD, 4, number of clk cycles per SCLK half-period; legal range 1..255.

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst_n  input  1  synchronous active-low reset.
cmd_valid  input  1  command present.
cmd_ready  output  1  controller can accept a command; high only in IDLE.
cmd_write  input  1  1 = write frame, 0 = read frame.
cmd_addr  input  7  register address.
cmd_wdata  input  8  write data; ignored for reads, where the data field is sent as 0x00.
rsp_valid  output  1  one-cycle pulse when a frame completes.
rsp_rdata  output  8  last 8 bits sampled from CIPO; held until the next frame completes.
busy  output  1  high from command accept until return to IDLE.
spi_sclk  output  1  SPI clock, idle low.
spi_ncs  output  1  chip select, active low.
spi_copi  output  1  controller-out data.
spi_cipo  input  1  controller-in data.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low (rst_n), sampled on the clk rising edge.
- Reset values: spi_sclk=0, spi_ncs=1, spi_copi=0, rsp_valid=0, rsp_rdata=0x00, busy=0, state=IDLE, cmd_ready=1.
- Frame layout: frame[15]=cmd_write, frame[14:8]=cmd_addr, frame[7:0]=cmd_wdata (0x00 on reads). Sent MSB first.
- Accept: a command is accepted on the edge where cmd_valid and cmd_ready are both high. On that edge:
  - the frame is latched;
  - spi_ncs goes to 0;
  - spi_copi takes frame[15];
  - busy goes to 1;
  - state moves to SETUP.
- States: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
  - SETUP: lasts H cycles (H = HALF_PERIOD). SCLK stays low.
  - SHIFT: 16 SCLK periods. Each period is H cycles low, then H cycles high.
    - Rising SCLK edge: sample spi_cipo into the receive shift register.
    - Falling SCLK edge: drive the next frame bit on spi_copi.
    - After the 16th falling edge, enter HOLD. No further COPI update on that edge.
  - HOLD: H cycles with nCS low and SCLK low. At the end, spi_ncs goes to 1, spi_copi goes to 0, and rsp_valid pulses for exactly 1 cycle. rsp_rdata is updated with receive bits [7:0] on that same edge.
  - GAP: H cycles with nCS high. On exit, busy goes to 0 and cmd_ready goes to 1.
- Timing invariants:
  - nCS is low for exactly 34·H cycles per frame.
  - SCLK gives exactly 16 rising edges per frame.
  - nCS stays high for at least H cycles between frames.
  - Minimum accept-to-accept spacing is 35·H cycles.
- rsp_valid pulses for write frames as well. rsp_rdata is then whatever was sampled on CIPO.
- While busy, cmd_valid and the command fields are ignored. The latched frame never changes mid-transaction.
- If cmd_valid is held high continuously, the next command is accepted on the first IDLE cycle. rsp_valid and a new accept never fall on the same cycle.
- Reset asserted mid-frame: on the next edge all outputs take their reset values. No rsp_valid is produced, and the partial frame is discarded.
- SCLK, nCS and COPI are driven straight from flops (glitch-free). CIPO is used without a synchroniser; the peripheral runs on the same clk.

Decomposition:
- Shared package spi_pkg holds:
  - FRAME_W=16, ADDR_W=7, DATA_W=8;
  - the RW_BIT=15 index;
  - the state encoding (IDLE, SETUP, SHIFT, HOLD, GAP).
  The peripheral uses the same package.
- One sub-module: spi_sclk_div. It holds the half-period counter and emits single-cycle rise_stb/fall_stb plus a phase_done strobe. The FSM and the shift registers stay in spi_reg_controller.

Test Plan:
1. H=4, write addr 0x00 data 0xFF -> COPI sampled on the 16 SCLK rising edges reads 0x80FF; nCS low exactly 136 cycles; a single rsp_valid pulse.
2. H=4, read addr 0x04, CIPO model returns 0xA5 in the data phase -> COPI frame 0x0400; rsp_rdata=0xA5 on the rsp_valid cycle and held afterwards.
3. H=4, cmd_valid held high with two back-to-back writes (0x01/0x3C, 0x02/0xC3) -> second accept exactly 140 cycles after the first; nCS high for 4 cycles between frames; two rsp_valid pulses.
4. H=4, cmd_valid pulsed with different fields mid-frame -> cmd_ready=0, frame on COPI unchanged, no extra transaction.
5. rst_n low after the 7th SCLK rising edge -> next edge: nCS=1, SCLK=0, COPI=0, busy=0, no rsp_valid; after release cmd_ready=1 and a new write completes normally.
6. H=1, write addr 0x7F data 0x5A -> frame 0xFF5A; nCS low 34 cycles; SCLK toggles every cycle during SHIFT.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register frame, used by both the controller
// and the peripheral.
//   FRAME_W / ADDR_W / DATA_W : frame, address and data field widths
//   RW_BIT                    : frame bit carrying the write flag
//   spi_state_e               : controller FSM states
//   build_frame()             : packs a command into the on-wire frame
package spi_pkg;

    localparam int FRAME_W = 16;
    localparam int ADDR_W  = 7;
    localparam int DATA_W  = 8;
    localparam int RW_BIT  = 15;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } spi_state_e;

    // Reads carry an all-zero data field so the peripheral sees a clean frame.
    function automatic logic [FRAME_W-1:0] build_frame(
        input logic              wr,
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] wdata
    );
        return {wr, addr, (wr ? wdata : {DATA_W{1'b0}})};
    endfunction

endpackage

// File: rtl/spi_sclk_div.sv
// Half-period timer and SCLK generator for spi_reg_controller.
//   clk, rst_n   : clock, synchronous active-low reset
//   run          : counter runs while high, held at zero otherwise
//   shift_en     : SCLK toggles at phase ends only while high
//   short_phase  : phase is one cycle shorter than HALF_PERIOD (min 1 cycle)
//   phase_done   : last cycle of the current phase
//   rise_stb     : SCLK rises on the coming edge
//   fall_stb     : SCLK falls on the coming edge
//   sclk         : registered SCLK, idle low
module spi_sclk_div #(
    parameter int HALF_PERIOD = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic shift_en,
    input  logic short_phase,
    output logic phase_done,
    output logic rise_stb,
    output logic fall_stb,
    output logic sclk
);

    localparam int         TC_SHORT_I = (HALF_PERIOD > 1) ? HALF_PERIOD - 2 : 0;
    localparam logic [7:0] TC_FULL    = 8'(HALF_PERIOD - 1);
    localparam logic [7:0] TC_SHORT   = 8'(TC_SHORT_I);

    logic [7:0] cnt_q, cnt_d;
    logic       sclk_q, sclk_d;
    logic [7:0] tc;

    always_comb begin
        tc         = short_phase ? TC_SHORT : TC_FULL;
        phase_done = run && (cnt_q == tc);
        rise_stb   = phase_done && shift_en && !sclk_q;
        fall_stb   = phase_done && shift_en && sclk_q;

        cnt_d = (!run || phase_done) ? 8'd0 : cnt_q + 8'd1;

        sclk_d = sclk_q;
        if (rise_stb) begin
            sclk_d = 1'b1;
        end else if (fall_stb) begin
            sclk_d = 1'b0;
        end
        if (!shift_en) begin
            sclk_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= 8'd0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

    assign sclk = sclk_q;

endmodule

// File: rtl/spi_reg_controller.sv
// SPI mode-0 initiator for the 16-bit register write/read frame.
//   clk, rst_n            : clock, synchronous active-low reset
//   cmd_valid/cmd_ready   : command handshake, ready only in IDLE
//   cmd_write/addr/wdata  : command fields (wdata sent as 0x00 on reads)
//   rsp_valid             : one-cycle pulse at frame completion
//   rsp_rdata             : last 8 CIPO bits of the latest completed frame
//   busy                  : accept through return to IDLE
//   spi_sclk/ncs/copi     : SPI outputs, all straight from flops
//   spi_cipo              : SPI input (same clock domain, no synchroniser)
module spi_reg_controller
    import spi_pkg::*;
#(
    parameter int HALF_PERIOD = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic              spi_sclk,
    output logic              spi_ncs,
    output logic              spi_copi,
    input  logic              spi_cipo
);

    spi_state_e         state_q, state_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [DATA_W-1:0]  rx_q, rx_d;
    logic [3:0]         bit_cnt_q, bit_cnt_d;
    logic               ncs_q, ncs_d;
    logic               copi_q, copi_d;
    logic               busy_q, busy_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;

    logic phase_done, rise_stb, fall_stb;

    // GAP runs one cycle short because the IDLE accept cycle completes the
    // H-cycle nCS-high gap, keeping back-to-back frames 35*H apart.
    spi_sclk_div #(
        .HALF_PERIOD(HALF_PERIOD)
    ) u_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (state_q != IDLE),
        .shift_en   (state_q == SHIFT),
        .short_phase(state_q == GAP),
        .phase_done (phase_done),
        .rise_stb   (rise_stb),
        .fall_stb   (fall_stb),
        .sclk       (spi_sclk)
    );

    always_comb begin
        state_d     = state_q;
        frame_d     = frame_q;
        rx_d        = rx_q;
        bit_cnt_d   = bit_cnt_q;
        ncs_d       = ncs_q;
        copi_d      = copi_q;
        busy_d      = busy_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    frame_d   = build_frame(cmd_write, cmd_addr, cmd_wdata);
                    ncs_d     = 1'b0;
                    copi_d    = cmd_write;
                    busy_d    = 1'b1;
                    bit_cnt_d = 4'd0;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                if (phase_done) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (rise_stb) begin
                    rx_d = {rx_q[DATA_W-2:0], spi_cipo};
                end
                // bit_cnt counts completed SCLK periods; the 16th falling
                // edge ends the frame without touching COPI.
                if (fall_stb) begin
                    if (bit_cnt_q == 4'd15) begin
                        state_d = HOLD;
                    end else begin
                        copi_d    = frame_q[4'd14 - bit_cnt_q];
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            HOLD: begin
                if (phase_done) begin
                    ncs_d       = 1'b1;
                    copi_d      = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = rx_q;
                    state_d     = GAP;
                end
            end
            GAP: begin
                if (phase_done) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= 4'd0;
            ncs_q       <= 1'b1;
            copi_q      <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            ncs_q       <= ncs_d;
            copi_q      <= copi_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Frame and receive shifter are pure data; their contents are
    // meaningless until the control path starts a frame.
    always_ff @(posedge clk) begin
        frame_q <= frame_d;
        rx_q    <= rx_d;
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = busy_q;
    assign spi_ncs   = ncs_q;
    assign spi_copi  = copi_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_spi_reg_controller.sv
// Bench for spi_reg_controller: instance 0 uses HALF_PERIOD=4, instance 1
// uses HALF_PERIOD=1. A monitor acts as the SPI peripheral (drives CIPO from
// a pattern, captures COPI on SCLK rises) and checks each frame's shape.
module tb_spi_reg_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic [1:0]      cmd_valid;
    logic [1:0]      cmd_write;
    logic [1:0][6:0] cmd_addr;
    logic [1:0][7:0] cmd_wdata;
    logic [1:0]      cipo;
    logic [1:0]      cmd_ready;
    logic [1:0]      rsp_valid;
    logic [1:0][7:0] rsp_rdata;
    logic [1:0]      busy;
    logic [1:0]      sclk;
    logic [1:0]      ncs;
    logic [1:0]      copi;

    spi_reg_controller #(.HALF_PERIOD(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
        .cmd_write(cmd_write[0]), .cmd_addr(cmd_addr[0]), .cmd_wdata(cmd_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .busy(busy[0]),
        .spi_sclk(sclk[0]), .spi_ncs(ncs[0]), .spi_copi(copi[0]), .spi_cipo(cipo[0])
    );

    spi_reg_controller #(.HALF_PERIOD(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
        .cmd_write(cmd_write[1]), .cmd_addr(cmd_addr[1]), .cmd_wdata(cmd_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .busy(busy[1]),
        .spi_sclk(sclk[1]), .spi_ncs(ncs[1]), .spi_copi(copi[1]), .spi_cipo(cipo[1])
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int hp(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic logic [15:0] model_frame(input logic w, input logic [6:0] a,
                                                input logic [7:0] d);
        logic [15:0] f;
        f[15]   = w;
        f[14:8] = a;
        f[7:0]  = w ? d : 8'h00;
        return f;
    endfunction

    // Pattern the peripheral model will shift out on CIPO for the next frame.
    logic [1:0][15:0] pat_next;

    // Monitor / peripheral-model state (written only by the monitor).
    int          cyc = 0;
    int          low_run[2], high_run[2], last_low[2], last_high[2];
    int          rise_cnt[2], tog_cnt[2], first_rise[2], last_fall[2];
    int          rsp_cnt[2], acc_cnt[2], acc_cyc[2], acc_gap[2], cidx[2];
    logic [15:0] cap[2], last_frame[2], pat_cur[2], exp_frame[2];
    logic [7:0]  exp_rd[2];
    logic        pending[2], aborted[2];
    logic [1:0]  prev_ncs  = 2'b11;
    logic [1:0]  prev_sclk = 2'b00;

    initial begin
        for (int i = 0; i < 2; i++) begin
            low_run[i] = 0; high_run[i] = 0; last_low[i] = 0; last_high[i] = 0;
            rise_cnt[i] = 0; tog_cnt[i] = 0; first_rise[i] = -1; last_fall[i] = -1;
            rsp_cnt[i] = 0; acc_cnt[i] = 0; acc_cyc[i] = 0; acc_gap[i] = 0; cidx[i] = 0;
            cap[i] = '0; last_frame[i] = '0; pat_cur[i] = '0; exp_frame[i] = '0;
            exp_rd[i] = '0; pending[i] = 1'b0; aborted[i] = 1'b0;
        end
        cipo = 2'b00;
    end

    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (rst_n && cmd_valid[i] && cmd_ready[i]) begin
                acc_gap[i]   = cyc - acc_cyc[i];
                acc_cyc[i]   = cyc;
                acc_cnt[i]++;
                exp_frame[i] = model_frame(cmd_write[i], cmd_addr[i], cmd_wdata[i]);
                pat_cur[i]   = pat_next[i];
                exp_rd[i]    = pat_next[i][7:0];
                pending[i]   = 1'b1;
            end
            if (rsp_valid[i]) begin
                rsp_cnt[i]++;
                chk("rsp_rdata", rsp_rdata[i], exp_rd[i]);
                chk("rsp_no_accept", cmd_valid[i] && cmd_ready[i], 0);
            end
            if (!ncs[i]) begin
                if (prev_ncs[i]) begin
                    last_high[i]  = high_run[i];
                    low_run[i]    = 0;
                    rise_cnt[i]   = 0;
                    tog_cnt[i]    = 0;
                    first_rise[i] = -1;
                    last_fall[i]  = -1;
                    cap[i]        = '0;
                    aborted[i]    = 1'b0;
                    cipo[i]       = pat_cur[i][15];
                    cidx[i]       = 14;
                end
                if (!rst_n) aborted[i] = 1'b1;
                if (sclk[i] != prev_sclk[i]) begin
                    tog_cnt[i]++;
                    if (sclk[i]) begin
                        if (rise_cnt[i] == 0) first_rise[i] = low_run[i];
                        cap[i] = {cap[i][14:0], copi[i]};
                        rise_cnt[i]++;
                    end else begin
                        last_fall[i] = low_run[i];
                        if (cidx[i] >= 0) begin
                            cipo[i] = pat_cur[i][cidx[i]];
                            cidx[i]--;
                        end
                    end
                end
                low_run[i]++;
            end else begin
                if (!prev_ncs[i]) begin
                    if (!aborted[i]) begin
                        chk("frame_had_accept", pending[i], 1);
                        chk("frame_bits", cap[i], exp_frame[i]);
                        chk("sclk_rises", rise_cnt[i], 16);
                        chk("sclk_toggles", tog_cnt[i], 32);
                        chk("ncs_low_cycles", low_run[i], 34 * hp(i));
                        chk("first_rise_off", first_rise[i], 2 * hp(i));
                        chk("last_fall_off", last_fall[i], 33 * hp(i));
                        chk("copi_after_frame", copi[i], 0);
                        last_frame[i] = cap[i];
                        last_low[i]   = low_run[i];
                    end
                    pending[i]  = 1'b0;
                    high_run[i] = 0;
                end
                high_run[i]++;
            end
            prev_ncs[i]  = ncs[i];
            prev_sclk[i] = sclk[i];
        end
    end

    task automatic send(input int i, input logic w, input logic [6:0] a,
                        input logic [7:0] d, input logic [15:0] pat);
        logic ok;
        ok = 1'b0;
        @(posedge clk); #1;
        pat_next[i]  = pat;
        cmd_write[i] = w;
        cmd_addr[i]  = a;
        cmd_wdata[i] = d;
        cmd_valid[i] = 1'b1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (cmd_ready[i]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
        cmd_valid[i] = 1'b0;
    endtask

    task automatic wait_rsp(input int i, input int n);
        for (int k = 0; k < 2000; k++) begin
            @(posedge clk);
            if (rsp_cnt[i] >= n) break;
        end
        repeat (10) @(posedge clk);
        chk("rsp_count", rsp_cnt[i], n);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int          r0, a0, rc;
        logic        w;
        logic [6:0]  a;
        logic [7:0]  d;
        logic [15:0] p;
        int          i;

        rst_n     = 1'b0;
        cmd_valid = '0;
        cmd_write = '0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        pat_next  = '0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("rst_ncs", ncs[0], 1);
        chk("rst_sclk", sclk[0], 0);
        chk("rst_copi", copi[0], 0);
        chk("rst_busy", busy[0], 0);
        chk("rst_rsp_valid", rsp_valid[0], 0);
        chk("rst_rsp_rdata", rsp_rdata[0], 8'h00);
        chk("rst_cmd_ready", cmd_ready[0], 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // 1: write 0x00 <- 0xFF
        send(0, 1'b1, 7'h00, 8'hFF, 16'($urandom));
        wait_rsp(0, 1);
        chk("t1_frame", last_frame[0], 16'h80FF);
        chk("t1_ncs_low", last_low[0], 136);

        // 2: read 0x04, peripheral returns 0xA5 in the data phase
        send(0, 1'b0, 7'h04, 8'($urandom), {8'($urandom), 8'hA5});
        wait_rsp(0, 2);
        chk("t2_frame", last_frame[0], 16'h0400);
        repeat (20) @(posedge clk);
        #1 chk("t2_rdata_held", rsp_rdata[0], 8'hA5);

        // 3: back-to-back writes with cmd_valid held high
        a0 = acc_cnt[0];
        @(posedge clk); #1;
        pat_next[0] = 16'($urandom);
        cmd_write[0] = 1'b1; cmd_addr[0] = 7'h01; cmd_wdata[0] = 8'h3C;
        cmd_valid[0] = 1'b1;
        for (int k = 0; k < 400 && acc_cnt[0] == a0; k++) @(posedge clk);
        #1;
        pat_next[0] = 16'($urandom);
        cmd_addr[0] = 7'h02; cmd_wdata[0] = 8'hC3;
        for (int k = 0; k < 400 && acc_cnt[0] == a0 + 1; k++) @(posedge clk);
        #1 cmd_valid[0] = 1'b0;
        chk("t3_accepts", acc_cnt[0], a0 + 2);
        chk("t3_accept_gap", acc_gap[0], 140);
        wait_rsp(0, 4);
        chk("t3_ncs_high_gap", last_high[0], 4);
        chk("t3_frame2", last_frame[0], 16'h82C3);

        // 4: command activity while busy must be ignored
        a0 = acc_cnt[0];
        send(0, 1'b1, 7'h15, 8'h6E, 16'($urandom));
        repeat (20) @(posedge clk); #1;
        cmd_write[0] = 1'b0; cmd_addr[0] = 7'h6A; cmd_wdata[0] = 8'h11;
        cmd_valid[0] = 1'b1;
        repeat (3) @(negedge clk);
        chk("t4_ready_busy", cmd_ready[0], 0);
        @(posedge clk); #1 cmd_valid[0] = 1'b0;
        wait_rsp(0, 5);
        chk("t4_frame", last_frame[0], 16'h956E);
        chk("t4_accepts", acc_cnt[0], a0 + 1);

        // 5: reset after the 7th SCLK rise
        send(0, 1'b1, 7'h33, 8'h99, 16'($urandom));
        for (int k = 0; k < 400 && rise_cnt[0] < 7; k++) @(posedge clk);
        #1 rst_n = 1'b0;
        r0 = rsp_cnt[0];
        @(posedge clk); #1;
        chk("t5_ncs", ncs[0], 1);
        chk("t5_sclk", sclk[0], 0);
        chk("t5_copi", copi[0], 0);
        chk("t5_busy", busy[0], 0);
        chk("t5_rsp_valid", rsp_valid[0], 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (40) @(posedge clk);
        chk("t5_no_rsp", rsp_cnt[0], r0);
        #1 chk("t5_ready", cmd_ready[0], 1);
        send(0, 1'b1, 7'h2B, 8'hD4, 16'($urandom));
        wait_rsp(0, r0 + 1);
        chk("t5_frame_after", last_frame[0], 16'hABD4);

        // 6: HALF_PERIOD=1 write 0x7F <- 0x5A
        send(1, 1'b1, 7'h7F, 8'h5A, 16'($urandom));
        wait_rsp(1, 1);
        chk("t6_frame", last_frame[1], 16'hFF5A);
        chk("t6_ncs_low", last_low[1], 34);

        // Randomized commands on both instances
        for (int n = 0; n < 10; n++) begin
            i  = int'($urandom_range(1, 0));
            w  = 1'($urandom);
            a  = 7'($urandom);
            d  = 8'($urandom);
            p  = 16'($urandom);
            rc = rsp_cnt[i];
            send(i, w, a, d, p);
            wait_rsp(i, rc + 1);
            chk("rand_frame", last_frame[i], model_frame(w, a, d));
            #1 chk("rand_rdata", rsp_rdata[i], p[7:0]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
